perips_bus_bridge: RTL and testbench

- Registered request bridge between the core's data-memory port and the regional peripheral decoder.
- Accepts one CPU access at a time and checks it against the peripheral address window.
- Drives the access onto the decoder's req/we/addr/data/ack interface and returns read data, or an error response when the access is out of window or times out.
- Isolates core timing from the combinational decode path and prevents bus hangs from unmapped regions.

---
 rtl/perips_bus_bridge_pkg.sv | 24 ++
 rtl/bridge_timeout_cnt.sv | 27 ++
 rtl/perips_bus_bridge.sv | 120 ++++++++++++
 tb/tb_perips_bus_bridge.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/perips_bus_bridge_pkg.sv
// perips_bus_bridge_pkg: shared state encoding, window defaults and decoder bank map.
package perips_bus_bridge_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    localparam logic [3:0]  WIN_NIBBLE_DEF = 4'h1;
    localparam int          TIMEOUT_DEF    = 64;
    localparam int          CNT_W_DEF      = 7;

    // Bank map the regional decoder carves out of the peripheral window.
    localparam logic [31:0] BANK_UART_BASE  = 32'h1000_0000;
    localparam logic [31:0] BANK_GPIO_BASE  = 32'h1000_1000;
    localparam logic [31:0] BANK_TIMER_BASE = 32'h1000_2000;
    localparam logic [31:0] BANK_SIZE       = 32'h0000_1000;

    function automatic logic in_window(input logic [31:0] addr, input logic [3:0] nib);
        return addr[31:28] == nib;
    endfunction

endpackage

// File: rtl/bridge_timeout_cnt.sv
// bridge_timeout_cnt: access-cycle counter flagging the final allowed cycle before a bus timeout.
module bridge_timeout_cnt
    import perips_bus_bridge_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d     = clr ? '0 : en ? cnt_q + CNT_W'(1) : cnt_q;
        expired_o = en && (cnt_q == CNT_W'(TIMEOUT - 1));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end

endmodule

// File: rtl/perips_bus_bridge.sv
// perips_bus_bridge: registered one-at-a-time bridge from the core data port to the
// regional peripheral decoder, with window check, timeout and error counting.
module perips_bus_bridge
    import perips_bus_bridge_pkg::*;
#(
    parameter logic [3:0] WIN_NIBBLE = WIN_NIBBLE_DEF,
    parameter int         TIMEOUT    = TIMEOUT_DEF,
    parameter int         CNT_W      = CNT_W_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m_req_i,
    input  logic        m_we_i,
    input  logic [31:0] m_addr_i,
    input  logic [31:0] m_wdata_i,
    output logic        m_gnt_o,
    output logic        m_rvalid_o,
    output logic [31:0] m_rdata_o,
    output logic        m_err_o,
    output logic        s_req_o,
    output logic        s_we_o,
    output logic [31:0] s_addr_o,
    output logic [31:0] s_data_o,
    input  logic [31:0] s_data_i,
    input  logic        s_ack_i,
    output logic [15:0] err_cnt_o
);

    state_e      state_q, state_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic [15:0] err_cnt_q, err_cnt_d;
    logic        cnt_clr, expired, err_hit;

    bridge_timeout_cnt #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_timeout (
        .clk       (clk),
        .rst       (rst),
        .clr       (cnt_clr),
        .en        (state_q == ACCESS),
        .expired_o (expired)
    );

    always_comb begin
        state_d   = state_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        cnt_clr   = 1'b0;
        err_hit   = 1'b0;
        case (state_q)
            IDLE: if (m_req_i) begin
                we_d    = m_we_i;
                addr_d  = m_addr_i;
                wdata_d = m_wdata_i;
                rdata_d = '0;
                if (in_window(m_addr_i, WIN_NIBBLE)) begin
                    state_d = ACCESS;
                    cnt_clr = 1'b1;
                end else begin
                    state_d = RESP;
                    err_d   = 1'b1;
                    err_hit = 1'b1;
                end
            end
            // An ack on the expiry cycle still completes the access cleanly.
            ACCESS: if (s_ack_i) begin
                rdata_d = we_q ? '0 : s_data_i;
                err_d   = 1'b0;
                state_d = RESP;
            end else if (expired) begin
                rdata_d = '0;
                err_d   = 1'b1;
                err_hit = 1'b1;
                state_d = RESP;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        err_cnt_d = (err_hit && err_cnt_q != 16'hFFFF) ? err_cnt_q + 16'd1 : err_cnt_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign m_gnt_o    = state_q == IDLE;
    assign m_rvalid_o = state_q == RESP;
    assign m_rdata_o  = m_rvalid_o ? rdata_q : '0;
    assign m_err_o    = m_rvalid_o && err_q;
    assign s_req_o    = state_q == ACCESS;
    assign s_we_o     = we_q;
    assign s_addr_o   = addr_q;
    assign s_data_o   = wdata_q;
    assign err_cnt_o  = err_cnt_q;

endmodule

// File: tb/tb_perips_bus_bridge.sv
// tb_perips_bus_bridge: directed and random checks of the bridge against a
// transaction-timeline model (cycles since acceptance, response cycle, response payload).
module tb_perips_bus_bridge;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        m_req_i = 1'b0, m_we_i = 1'b0;
    logic [31:0] m_addr_i = '0, m_wdata_i = '0;
    logic        m_gnt_o, m_rvalid_o, m_err_o;
    logic [31:0] m_rdata_o;
    logic        s_req_o, s_we_o;
    logic [31:0] s_addr_o, s_data_o;
    logic [31:0] s_data_i = '0;
    logic        s_ack_i = 1'b0;
    logic [15:0] err_cnt_o;

    perips_bus_bridge #(
        .WIN_NIBBLE (4'h1),
        .TIMEOUT    (TO),
        .CNT_W      (3)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .m_req_i    (m_req_i),
        .m_we_i     (m_we_i),
        .m_addr_i   (m_addr_i),
        .m_wdata_i  (m_wdata_i),
        .m_gnt_o    (m_gnt_o),
        .m_rvalid_o (m_rvalid_o),
        .m_rdata_o  (m_rdata_o),
        .m_err_o    (m_err_o),
        .s_req_o    (s_req_o),
        .s_we_o     (s_we_o),
        .s_addr_o   (s_addr_o),
        .s_data_o   (s_data_o),
        .s_data_i   (s_data_i),
        .s_ack_i    (s_ack_i),
        .err_cnt_o  (err_cnt_o)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    // Model: an accepted transaction is "busy" for a number of cycles; age counts
    // cycles since acceptance and rsp_age is the cycle the response appears (0 = not yet known).
    bit          busy = 1'b0;
    int          age = 0, rsp_age = 0;
    bit          tx_we, rsp_err;
    logic [31:0] tx_addr, tx_wdata, rsp_data;
    int          errcnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare();
        bit resp = busy && age == rsp_age;
        bit sreq = busy && !resp;
        chk("gnt", 32'(m_gnt_o), 32'(!busy));
        chk("rvalid", 32'(m_rvalid_o), 32'(resp));
        chk("rdata", m_rdata_o, resp ? rsp_data : 32'h0);
        chk("err", 32'(m_err_o), 32'(resp && rsp_err));
        chk("s_req", 32'(s_req_o), 32'(sreq));
        chk("err_cnt", 32'(err_cnt_o), 32'(errcnt));
        if (sreq) begin
            chk("s_we", 32'(s_we_o), 32'(tx_we));
            chk("s_addr", s_addr_o, tx_addr);
            chk("s_data", s_data_o, tx_wdata);
        end
    endtask

    task automatic step(input bit req, input bit we, input logic [31:0] addr,
                        input logic [31:0] wdata, input bit ack, input logic [31:0] sdata);
        m_req_i = req; m_we_i = we; m_addr_i = addr; m_wdata_i = wdata;
        s_ack_i = ack; s_data_i = sdata;
        if (!busy) begin
            if (req) begin
                busy = 1'b1; age = 1;
                tx_we = we; tx_addr = addr; tx_wdata = wdata;
                if (addr[31:28] != 4'h1) begin
                    rsp_age = 1; rsp_err = 1'b1; rsp_data = '0;
                    if (errcnt < 65535) errcnt++;
                end else rsp_age = 0;
            end
        end else if (age == rsp_age) busy = 1'b0;
        else begin
            if (ack) begin
                rsp_age = age + 1; rsp_err = 1'b0; rsp_data = tx_we ? 32'h0 : sdata;
            end else if (age == TO) begin
                rsp_age = age + 1; rsp_err = 1'b1; rsp_data = '0;
                if (errcnt < 65535) errcnt++;
            end
            age++;
        end
        @(negedge clk);
        compare();
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    endtask

    initial begin
        int hi;
        repeat (2) @(negedge clk);
        compare();
        chk("reset_gnt", 32'(m_gnt_o), 32'h1);
        rst = 1'b1;

        // Read, combinational ack
        step(1'b1, 1'b0, 32'h1000_0004, 32'h0, 1'b0, 32'h0);
        chk("rd_sreq", 32'(s_req_o), 32'h1);
        chk("rd_saddr", s_addr_o, 32'h1000_0004);
        step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'hA5A5_0001);
        chk("rd_rvalid", 32'(m_rvalid_o), 32'h1);
        chk("rd_rdata", m_rdata_o, 32'hA5A5_0001);
        chk("rd_err", 32'(m_err_o), 32'h0);
        idle();
        chk("rd_gnt_back", 32'(m_gnt_o), 32'h1);

        // Write, ack on third access cycle
        step(1'b1, 1'b1, 32'h1000_0008, 32'h1234_5678, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            chk("wr_saddr", s_addr_o, 32'h1000_0008);
            chk("wr_sdata", s_data_o, 32'h1234_5678);
            chk("wr_swe", 32'(s_we_o), 32'h1);
            step(1'b0, 1'b0, 32'h0, 32'h0, i == 2, 32'hDEAD_BEEF);
        end
        chk("wr_rvalid", 32'(m_rvalid_o), 32'h1);
        chk("wr_rdata", m_rdata_o, 32'h0);
        chk("wr_err", 32'(m_err_o), 32'h0);
        idle();

        // Out of window
        step(1'b1, 1'b0, 32'h2000_0000, 32'h0, 1'b1, 32'h5555_5555);
        chk("oow_sreq", 32'(s_req_o), 32'h0);
        chk("oow_rvalid", 32'(m_rvalid_o), 32'h1);
        chk("oow_err", 32'(m_err_o), 32'h1);
        chk("oow_errcnt", 32'(err_cnt_o), 32'h1);
        idle();

        // Timeout
        step(1'b1, 1'b0, 32'h1000_0010, 32'h0, 1'b0, 32'h0);
        hi = 0;
        for (int i = 0; i < 5; i++) begin
            hi += int'(s_req_o);
            if (i < 4) step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        end
        chk("to_sreq_cycles", 32'(hi), 32'd4);
        chk("to_rvalid", 32'(m_rvalid_o), 32'h1);
        chk("to_err", 32'(m_err_o), 32'h1);
        chk("to_rdata", m_rdata_o, 32'h0);
        chk("to_errcnt", 32'(err_cnt_o), 32'h2);
        idle();

        // Ack coincident with expiry
        step(1'b1, 1'b0, 32'h1000_0014, 32'h0, 1'b0, 32'h0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'h0, 32'h0, i == 3, 32'hCAFE_0000);
        chk("co_rvalid", 32'(m_rvalid_o), 32'h1);
        chk("co_err", 32'(m_err_o), 32'h0);
        chk("co_rdata", m_rdata_o, 32'hCAFE_0000);
        chk("co_errcnt", 32'(err_cnt_o), 32'h2);
        idle();

        // Asynchronous reset in the middle of an access
        step(1'b1, 1'b0, 32'h1000_0018, 32'h0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        chk("rst_pre_sreq", 32'(s_req_o), 32'h1);
        #2 rst = 1'b0;
        #1;
        chk("rst_sreq", 32'(s_req_o), 32'h0);
        chk("rst_rvalid", 32'(m_rvalid_o), 32'h0);
        chk("rst_gnt", 32'(m_gnt_o), 32'h1);
        chk("rst_errcnt", 32'(err_cnt_o), 32'h0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        busy = 1'b0; errcnt = 0;
        compare();
        step(1'b1, 1'b0, 32'h1000_0020, 32'h0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h1111_2222);
        chk("rst_rd_rvalid", 32'(m_rvalid_o), 32'h1);
        chk("rst_rd_rdata", m_rdata_o, 32'h1111_2222);
        chk("rst_rd_errcnt", 32'(err_cnt_o), 32'h0);
        idle();

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] a = $urandom;
            if ($urandom_range(0, 4) != 0) a[31:28] = 4'h1;
            step($urandom_range(0, 9) < 7, 1'($urandom), a, $urandom,
                 $urandom_range(0, 3) == 0, $urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
